// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath: sequencing, mux selects, ALU decode, memory stall.
// Define MIPS_CTRL_BNE_EN to add bne (op 000101) support through the BRANCH state.
module mips_multicycle_ctrl #(
  parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {valid, alu_control}; unknown funct codes are flagged invalid.
  function automatic logic [3:0] alu_decode(input logic [5:0] fn);
    logic [3:0] r;
    case (fn)
      6'b100000: r = {1'b1, ALU_ADD};
      6'b100010: r = {1'b1, ALU_SUB};
      6'b100100: r = {1'b1, ALU_AND};
      6'b100101: r = {1'b1, ALU_OR};
      6'b101010: r = {1'b1, ALU_SLT};
      default:   r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic       is_sw_q, is_sw_d;
`ifdef MIPS_CTRL_BNE_EN
  logic       is_bne_q, is_bne_d;
`endif
  logic       mem_rdy_s;
  logic       pc_write_s;
  logic       branch_s;
  logic       br_cond_s;
  logic [3:0] fn_dec_s;

  assign mem_rdy_s = mem_ready | ~MEM_WAIT_EN_DEFAULT;
  assign state     = state_q;

  // State register plus the instruction-class flags latched in DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      is_sw_q  <= 1'b0;
`ifdef MIPS_CTRL_BNE_EN
      is_bne_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      is_sw_q  <= is_sw_d;
`ifdef MIPS_CTRL_BNE_EN
      is_bne_q <= is_bne_d;
`endif
    end
  end

  // Next-state and output decode; rst low keeps every output at its zero default.
  always_comb begin
    state_d     = state_q;
    is_sw_d     = is_sw_q;
`ifdef MIPS_CTRL_BNE_EN
    is_bne_d    = is_bne_q;
    br_cond_s   = zero ^ is_bne_q;
`else
    br_cond_s   = zero;
`endif
    fn_dec_s    = alu_decode(funct);
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b000;
    illegal_op  = 1'b0;
    pc_write_s  = 1'b0;
    branch_s    = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b   = 2'b01;
          alu_control = ALU_ADD;
          if (mem_rdy_s) begin
            ir_write   = 1'b1;
            pc_write_s = 1'b1;
            state_d    = S_DECODE;
          end else begin
            state_d    = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b   = 2'b11;
          alu_control = ALU_ADD;
          case (op)
            OP_LW:    begin state_d = S_MEMADR; is_sw_d = 1'b0; end
            OP_SW:    begin state_d = S_MEMADR; is_sw_d = 1'b1; end
            OP_RTYPE: begin
              if (fn_dec_s[3]) begin
                state_d    = S_EXEC;
              end else begin
                state_d    = S_FETCH;
                illegal_op = 1'b1;
              end
            end
            OP_BEQ: begin
              state_d  = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
              is_bne_d = 1'b0;
`endif
            end
`ifdef MIPS_CTRL_BNE_EN
            OP_BNE:   begin state_d = S_BRANCH; is_bne_d = 1'b1; end
`endif
            OP_ADDI:  state_d = S_ADDIEX;
            OP_J:     state_d = S_JUMP;
            default:  begin state_d = S_FETCH; illegal_op = 1'b1; end
          endcase
        end
        S_MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
          state_d     = is_sw_q ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          iord    = 1'b1;
          state_d = mem_rdy_s ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          state_d   = mem_rdy_s ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = fn_dec_s[2:0];
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_src      = 2'b01;
          branch_s    = 1'b1;
          state_d     = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
          state_d     = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_write_s = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      state_d = S_FETCH;
    end
    pc_en = pc_write_s | (branch_s & br_cond_s);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus randomized instruction streams
// checked against a per-instruction path model and a per-state output table.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       iord, mw, irw, pcen, rw, rd, m2r, asa;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    logic       ill;
  } ctl_t;

  ctl_t outs_s;
  int   path_st[$];
  bit   path_mr[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

  always #5 clk = ~clk;

  always_comb outs_s = {iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg,
                        alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // What each state must drive: v = values, m = which fields the state defines.
  function automatic void model(input int st, input bit mr, input bit z, input logic [5:0] fn,
                                input bit ill, input bit bne, output ctl_t v, output ctl_t m);
    v = '0; m = '0;
    m.mw = 1'b1; m.irw = 1'b1; m.pcen = 1'b1; m.rw = 1'b1; m.ill = 1'b1;
    case (st)
      0:  begin m.iord = 1'b1; m.asa = 1'b1; m.asb = 2'b11; m.pcs = 2'b11; m.alu = 3'b111;
                v.asb = 2'b01; v.alu = 3'b010; v.irw = mr; v.pcen = mr; end
      1:  begin m.asa = 1'b1; m.asb = 2'b11; m.alu = 3'b111; v.asb = 2'b11; v.alu = 3'b010; v.ill = ill; end
      2:  begin m.asa = 1'b1; m.asb = 2'b11; m.alu = 3'b111; v.asa = 1'b1; v.asb = 2'b10; v.alu = 3'b010; end
      3:  begin m.iord = 1'b1; v.iord = 1'b1; end
      4:  begin m.rd = 1'b1; m.m2r = 1'b1; v.rw = 1'b1; v.m2r = 1'b1; end
      5:  begin m.iord = 1'b1; v.iord = 1'b1; v.mw = 1'b1; end
      6:  begin m.asa = 1'b1; m.asb = 2'b11; m.alu = 3'b111; v.asa = 1'b1; v.alu = alu_of(fn); end
      7:  begin m.rd = 1'b1; m.m2r = 1'b1; v.rw = 1'b1; v.rd = 1'b1; end
      8:  begin m.asa = 1'b1; m.asb = 2'b11; m.alu = 3'b111; m.pcs = 2'b11;
                v.asa = 1'b1; v.alu = 3'b110; v.pcs = 2'b01; v.pcen = z ^ bne; end
      9:  begin m.asa = 1'b1; m.asb = 2'b11; m.alu = 3'b111; v.asa = 1'b1; v.asb = 2'b10; v.alu = 3'b010; end
      10: begin m.rd = 1'b1; m.m2r = 1'b1; v.rw = 1'b1; end
      11: begin m.pcs = 2'b11; v.pcs = 2'b10; v.pcen = 1'b1; end
      default: ;
    endcase
  endfunction

  task automatic add_state(input int st, input int waits);
    repeat (waits) begin path_st.push_back(st); path_mr.push_back(1'b0); end
    path_st.push_back(st);
    path_mr.push_back(1'b1);
  endtask

  // Sequence of states an instruction walks through, including memory wait cycles.
  task automatic build_path(input logic [5:0] iop, input logic [5:0] fn, input int wf, input int wr,
                            input int ww, output bit ill, output bit bne);
    path_st.delete(); path_mr.delete();
    ill = 1'b0; bne = 1'b0;
    add_state(0, wf); add_state(1, 0);
    case (iop)
      LW:   begin add_state(2, 0); add_state(3, wr); add_state(4, 0); end
      SW:   begin add_state(2, 0); add_state(5, ww); end
      RT:   if (funct_ok(fn)) begin add_state(6, 0); add_state(7, 0); end else ill = 1'b1;
      BEQ:  add_state(8, 0);
`ifdef MIPS_CTRL_BNE_EN
      BNE:  begin add_state(8, 0); bne = 1'b1; end
`endif
      ADDI: begin add_state(9, 0); add_state(10, 0); end
      JMP:  add_state(11, 0);
      default: ill = 1'b1;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b0; op = LW; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if (state !== 4'd0 || outs_s !== ctl_t'(0)) begin
        errors++;
        $display("FAIL reset_hold: state=%0d outs=%h required state=0 outs=0", state, outs_s);
      end
      adv();
    end
    rst = 1'b1;
    #4;
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fetch: state=%0d ir_write=%b pc_en=%b required 0,1,1", state, ir_write, pc_en);
    end
    adv();
    for (int s = 1; s <= 4; s++) begin
      checks++;
      if (state !== 4'(s)) begin
        errors++;
        $display("FAIL reset_lw_walk: state=%0d required %0d", state, s);
      end
      adv();
    end
  endtask

  task automatic test_lw();
    int seq[5] = '{0, 1, 2, 3, 4};
    op = LW; mem_ready = 1'b1;
    foreach (seq[i]) begin
      #4;
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL lw_state: state=%0d required %0d", state, seq[i]);
      end
      if (seq[i] == 4) begin
        checks++;
        if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
          errors++;
          $display("FAIL lw_wb: rw,m2r,rd=%b required 110", {reg_write, mem_to_reg, reg_dst});
        end
      end
      adv();
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL lw_done: state=%0d required 0", state);
    end
  endtask

  task automatic test_sw_wait();
    int seq[6] = '{0, 1, 2, 5, 5, 5};
    bit mrs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    op = SW;
    foreach (seq[i]) begin
      mem_ready = mrs[i];
      #4;
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL sw_state: state=%0d required %0d", state, seq[i]);
      end
      if (seq[i] == 5) begin
        checks++;
        if ({mem_write, iord} !== 2'b11) begin
          errors++;
          $display("FAIL sw_memwr: mw,iord=%b required 11", {mem_write, iord});
        end
      end
      adv();
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL sw_done: state=%0d required 0", state);
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] exp_alu);
    int seq[4] = '{0, 1, 6, 7};
    op = RT; funct = fn; mem_ready = 1'b1;
    foreach (seq[i]) begin
      #4;
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL rtype_state: state=%0d required %0d", state, seq[i]);
      end
      if (seq[i] == 6) begin
        checks++;
        if (alu_control !== exp_alu) begin
          errors++;
          $display("FAIL rtype_alu: alu=%b required %b", alu_control, exp_alu);
        end
      end
      if (seq[i] == 7) begin
        checks++;
        if ({reg_write, reg_dst} !== 2'b11) begin
          errors++;
          $display("FAIL rtype_wb: rw,rd=%b required 11", {reg_write, reg_dst});
        end
      end
      adv();
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL rtype_done: state=%0d required 0", state);
    end
  endtask

  task automatic test_branch(input logic [5:0] bop, input bit z, input bit exp_pcen);
    int seq[3] = '{0, 1, 8};
    op = bop; zero = z; mem_ready = 1'b1;
    foreach (seq[i]) begin
      #4;
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL branch_state: state=%0d required %0d", state, seq[i]);
      end
      if (seq[i] == 8) begin
        checks++;
        if (pc_en !== exp_pcen || pc_src !== 2'b01) begin
          errors++;
          $display("FAIL branch_pc: pc_en=%b pc_src=%b required %b 01", pc_en, pc_src, exp_pcen);
        end
      end
      adv();
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL branch_done: state=%0d required 0", state);
    end
  endtask

  task automatic test_illegal(input logic [5:0] iop);
    op = iop; mem_ready = 1'b1;
    #4;
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_fetch: illegal_op=%b required 0", illegal_op);
    end
    adv();
    #4;
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL illegal_decode: state=%0d illegal_op=%b required 1 1", state, illegal_op);
    end
    adv();
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after: state=%0d illegal_op=%b required 0 0", state, illegal_op);
    end
  endtask

  task automatic test_jump();
    int seq[3] = '{0, 1, 11};
    op = JMP; mem_ready = 1'b1;
    foreach (seq[i]) begin
      #4;
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++;
        $display("FAIL jump_state: state=%0d required %0d", state, seq[i]);
      end
      if (seq[i] == 11) begin
        checks++;
        if (pc_en !== 1'b1 || pc_src !== 2'b10) begin
          errors++;
          $display("FAIL jump_pc: pc_en=%b pc_src=%b required 1 10", pc_en, pc_src);
        end
      end
      adv();
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL jump_done: state=%0d required 0", state);
    end
  endtask

  task automatic test_async_reset();
    op = SW; mem_ready = 1'b1;
    repeat (3) adv();
    mem_ready = 1'b0;
    checks++;
    if (state !== 4'd5) begin
      errors++;
      $display("FAIL arst_setup: state=%0d required 5", state);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || mem_write !== 1'b0 || iord !== 1'b0) begin
      errors++;
      $display("FAIL arst_drop: state=%0d mw=%b iord=%b required 0 0 0", state, mem_write, iord);
    end
    #2 rst = 1'b1;
    adv();
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b0) begin
      errors++;
      $display("FAIL arst_restart: state=%0d ir_write=%b required 0 0", state, ir_write);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{LW, SW, RT, RT, BEQ, BNE, ADDI, JMP};
    for (int n = 0; n < 120; n++) begin
      logic [5:0] iop, ifn;
      bit ill, bne;
      ctl_t v, m;
      iop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      ifn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : alu_fn_pick($urandom_range(0, 4));
      build_path(iop, ifn, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), ill, bne);
      foreach (path_st[i]) begin
        mem_ready = (path_st[i] inside {0, 3, 5}) ? path_mr[i] : 1'($urandom);
        op        = (path_st[i] == 1) ? iop : 6'($urandom);
        funct     = ifn;
        zero      = 1'($urandom);
        #4;
        model(path_st[i], mem_ready, zero, ifn, ill, bne, v, m);
        checks++;
        if (state !== 4'(path_st[i]) || (outs_s & m) !== (v & m)) begin
          errors++;
          $display("FAIL random op=%b fn=%b: state=%0d outs=%h required state=%0d outs=%h (mask %h)",
                   iop, ifn, state, outs_s & m, path_st[i], v & m, m);
        end
        adv();
      end
    end
  endtask

  function automatic logic [5:0] alu_fn_pick(input int k);
    case (k)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      default: return 6'b101010;
    endcase
  endfunction

  initial begin
    adv();
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype(6'b101010, 3'b111);
    test_rtype(6'b100100, 3'b000);
    test_branch(BEQ, 1'b1, 1'b1);
    test_branch(BEQ, 1'b0, 1'b0);
    test_illegal(6'b111111);
    funct = 6'b000111;
    test_illegal(RT);
    test_jump();
`ifdef MIPS_CTRL_BNE_EN
    test_branch(BNE, 1'b0, 1'b1);
    test_branch(BNE, 1'b1, 1'b0);
`else
    test_illegal(BNE);
`endif
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore control FSM for the multicycle MIPS datapath. It sequences the datapath registers and drives every select of the 2:1 and 4:1 datapath muxes: IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB and PCSrc. It also decodes the ALU operation and stalls on a memory-ready handshake. It sits between the instruction register (op/funct) and the datapath built from the mux2_32 / mux4_32 cells.

Parameters:
MEM_WAIT_EN_DEFAULT, 1, 1 = honour mem_ready; 0 = treat mem_ready as constantly 1 (single-cycle memory).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
op  in  6  instruction opcode [31:26]
funct  in  6  instruction funct [5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake; access completes in the cycle it is 1
iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write enable
ir_write  out  1  instruction register load
pc_en  out  1  PC load = pc_write | (branch & zero)
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = memory data
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal_op  out  1  one-cycle pulse on an undecodable instruction
state  out  4  current state, for debug and the bench

Behaviour:
- Reset (rst=0, asynchronous): state <= FETCH. While rst=0, every enable (mem_write, ir_write, pc_en, reg_write) and illegal_op is forced to 0, and all selects are 0.
- Outputs are a pure decode of state (Moore), except the mem_ready gating noted below. A state advances on the rising clk.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge, with all enables 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00. ir_write and pc_en are 1 only in a cycle where mem_ready=1. FETCH holds until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target precompute). Next state by op:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - other -> FETCH with illegal_op=1 for this cycle
- R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal, handled as above.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEMWR: iord=1, mem_write=1 held stable for the whole stay. Leaves to FETCH in the cycle mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct, then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1 so pc_en=zero, then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- Latency with mem_ready tied to 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3. Each memory wait cycle adds one.
- op and funct are sampled only in DECODE (and EXEC for funct). Changes in other states have no effect.
- Reset asserted mid-instruction: the enables drop in the same cycle (asynchronous), and the FSM restarts at FETCH once rst=1.

Optional Feature:
MIPS_CTRL_BNE_EN
- Defined: op 000101 (bne) from DECODE goes to BRANCH. BRANCH then drives pc_en = ~zero for bne and pc_en = zero for beq; a one-bit registered flag latched in DECODE selects which.
- Undefined: op 000101 is illegal (illegal_op pulse, return to FETCH).

Test Plan:
- Reset: hold rst=0 for 3 cycles with op=100011, then release. Required: state=0, all enables 0 during reset; first ir_write=1 and pc_en=1 in the first FETCH cycle after release with mem_ready=1.
- lw, mem_ready=1: op=100011. Required state sequence 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1, reg_dst=0.
- sw with a memory wait: op=101011, mem_ready=0 for 2 cycles in MEMWR. Required: mem_write=1 for 3 consecutive cycles, iord=1, then state=0.
- R-type: op=000000, funct=101010. Required: alu_control=111 in EXEC, then reg_write=1, reg_dst=1 in ALUWB. Repeat with funct=100100 -> alu_control=000.
- beq: zero=1 -> pc_en=1, pc_src=01 in BRANCH. zero=0 -> pc_en=0. Both take 3 cycles.
- Illegal and jump:
  - op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then state=0.
  - op=000010 -> pc_en=1, pc_src=10 in JUMP.
  - With MIPS_CTRL_BNE_EN defined: op=000101, zero=0 -> pc_en=1.
